// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first magnitude comparator built around a 1-bit l/e/g slice.
// Captures two operands on start and reports lt/eq/gt with a one-cycle done pulse.
module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int NW = $clog2(WIDTH + 1),
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [NW-1:0]    nbits
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic [NW-1:0]    nbits_q, nbits_d;

    logic sx, sy, sl, sg, se;

    // 1-bit compare slice on the current bit position
    assign sx = ra_q[idx_q];
    assign sy = rb_q[idx_q];
    assign sl = ~sx & sy;
    assign sg = sx & ~sy;
    assign se = ~(sl | sg);

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        nbits_d   = nbits_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    ra_d      = a;
                    rb_d      = b;
                    idx_d     = IW'(WIDTH - 1);
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    eq_d      = 1'b0;
                    gt_d      = 1'b0;
                    nbits_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                nbits_d = nbits_q + NW'(1);
                if (!decided_q && (sl | sg)) begin
                    lt_d      = sl;
                    gt_d      = sg;
                    decided_d = 1'b1;
                end
                if ((EARLY_EXIT && (sl | sg)) || idx_q == '0) begin
                    state_d = S_DONE;
                    eq_d    = ~decided_q & se;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            nbits_q   <= '0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            nbits_q   <= nbits_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign lt    = lt_q;
    assign eq    = eq_q;
    assign gt    = gt_q;
    assign nbits = nbits_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: one early-exit and one full-scan instance,
// checked every cycle against an arithmetic model plus literal vectors.
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_s = '0;
    logic [7:0] b_s = '0;
    logic       start_s [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       lt_w    [2];
    logic       eq_w    [2];
    logic       gt_w    [2];
    logic [3:0] nb_w    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // index 0: full scan, index 1: early exit
    serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s), .b(b_s),
        .busy(busy_w[0]), .done(done_w[0]), .lt(lt_w[0]), .eq(eq_w[0]),
        .gt(gt_w[0]), .nbits(nb_w[0])
    );

    serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s), .b(b_s),
        .busy(busy_w[1]), .done(done_w[1]), .lt(lt_w[1]), .eq(eq_w[1]),
        .gt(gt_w[1]), .nbits(nb_w[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // model: remaining RUN cycles, done flag, published results
    int cnt [2];
    bit m_done [2];
    bit m_lt [2], m_eq [2], m_gt [2];
    int m_n [2];
    bit p_lt [2], p_eq [2], p_gt [2];
    int p_n [2];
    int mk, mm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cnt[d] = 0; m_done[d] = 0;
                m_lt[d] = 0; m_eq[d] = 0; m_gt[d] = 0; m_n[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_done[d] = 0;
                if (start_s[d] && cnt[d] == 0) begin
                    mk = 0;
                    while (mk < 8 && a_s[7-mk] == b_s[7-mk]) mk++;
                    mm = (d == 1) ? ((mk + 1 > 8) ? 8 : mk + 1) : 8;
                    cnt[d] = mm;
                    p_lt[d] = a_s < b_s;
                    p_eq[d] = a_s == b_s;
                    p_gt[d] = a_s > b_s;
                    p_n[d] = mm;
                    m_lt[d] = 0; m_eq[d] = 0; m_gt[d] = 0; m_n[d] = 0;
                end else if (cnt[d] > 0) begin
                    cnt[d]--;
                    if (cnt[d] == 0) begin
                        m_done[d] = 1;
                        m_lt[d] = p_lt[d]; m_eq[d] = p_eq[d];
                        m_gt[d] = p_gt[d]; m_n[d] = p_n[d];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d), int'(busy_w[d]), int'(cnt[d] > 0));
                chk($sformatf("done%0d", d), int'(done_w[d]), int'(m_done[d]));
                if (cnt[d] == 0) begin
                    chk($sformatf("lt%0d", d), int'(lt_w[d]), int'(m_lt[d]));
                    chk($sformatf("eq%0d", d), int'(eq_w[d]), int'(m_eq[d]));
                    chk($sformatf("gt%0d", d), int'(gt_w[d]), int'(m_gt[d]));
                    chk($sformatf("nbits%0d", d), int'(nb_w[d]), m_n[d]);
                end
            end
        end
    end

    task automatic go(input int d, input logic [7:0] av, input logic [7:0] bv,
                      output int lat);
        a_s = av; b_s = bv; start_s[d] = 1'b1; lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1 start_s[d] = 1'b0;
            @(negedge clk);
            if (done_w[d]) begin lat = n; break; end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic expect_res(input string nm, input int d, input int lat,
                              input int elat, input int elt, input int eeq,
                              input int egt, input int en);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_lt"}, int'(lt_w[d]), elt);
        chk({nm, "_eq"}, int'(eq_w[d]), eeq);
        chk({nm, "_gt"}, int'(gt_w[d]), egt);
        chk({nm, "_nbits"}, int'(nb_w[d]), en);
    endtask

    task automatic chk_zero(input string nm, input int d);
        chk({nm, "_busy"}, int'(busy_w[d]), 0);
        chk({nm, "_done"}, int'(done_w[d]), 0);
        chk({nm, "_lt"}, int'(lt_w[d]), 0);
        chk({nm, "_eq"}, int'(eq_w[d]), 0);
        chk({nm, "_gt"}, int'(gt_w[d]), 0);
        chk({nm, "_nbits"}, int'(nb_w[d]), 0);
    endtask

    initial begin
        int lat, nd, t1, t2, l1, g2, n1, n2;
        logic [7:0] ra, rb;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst0", 0);
        chk_zero("rst1", 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // T1: reset mid-RUN
        a_s = 8'h3C; b_s = 8'h3C; start_s[1] = 1'b1;
        @(posedge clk); #1 start_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("t1_mid", 1);
        chk_zero("t1_other", 0);
        @(posedge clk); #1 rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[1]) nd++;
        end
        chk("t1_no_done", nd, 0);

        // T2..T4 directed
        go(1, 8'hA5, 8'h25, lat); expect_res("t2", 1, lat, 2, 0, 0, 1, 1);
        go(1, 8'h3C, 8'h3C, lat); expect_res("t3", 1, lat, 9, 0, 1, 0, 8);
        go(1, 8'h10, 8'h11, lat); expect_res("t4", 1, lat, 9, 1, 0, 0, 8);
        go(0, 8'h80, 8'h7F, lat); expect_res("t4f", 0, lat, 9, 0, 0, 1, 8);
        go(0, 8'hA5, 8'h25, lat); expect_res("t2f", 0, lat, 9, 0, 0, 1, 8);
        go(0, 8'h3C, 8'h3C, lat); expect_res("t3f", 0, lat, 9, 0, 1, 0, 8);
        go(1, 8'h00, 8'h80, lat); expect_res("msb", 1, lat, 2, 1, 0, 0, 1);
        go(1, 8'hFF, 8'hFE, lat); expect_res("lsb", 1, lat, 9, 0, 0, 1, 8);

        // T5: back-to-back with start held high
        @(posedge clk); #1;
        a_s = 8'd1; b_s = 8'd2; start_s[1] = 1'b1;
        nd = 0; t1 = 0; t2 = 0; l1 = 0; g2 = 0; n1 = 0; n2 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin a_s = 8'd2; b_s = 8'd1; end
            @(negedge clk);
            if (done_w[1]) begin
                nd++;
                if (nd == 1) begin t1 = n; l1 = int'(lt_w[1]); n1 = int'(nb_w[1]); end
                else begin t2 = n; g2 = int'(gt_w[1]); n2 = int'(nb_w[1]); end
            end
            if (nd == 2) begin start_s[1] = 1'b0; break; end
        end
        start_s[1] = 1'b0;
        chk("t5_ndone", nd, 2);
        chk("t5_t1", t1, 8);
        chk("t5_t2", t2, 16);
        chk("t5_lt", l1, 1);
        chk("t5_gt", g2, 1);
        chk("t5_n1", n1, 7);
        chk("t5_n2", n2, 7);

        // T6: start while busy is ignored
        @(posedge clk); #1;
        a_s = 8'd3; b_s = 8'd9; start_s[1] = 1'b1; lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin
                a_s = 8'd200; b_s = 8'd1; start_s[1] = 1'b1;
            end else begin
                start_s[1] = 1'b0;
            end
            @(negedge clk);
            if (done_w[1]) begin lat = n; break; end
        end
        start_s[1] = 1'b0;
        if (lat < 0) chk("t6_timeout", 0, 1);
        expect_res("t6", 1, lat, 6, 1, 0, 0, 5);

        // randomized ops, checked by the model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            go(int'($urandom_range(0, 1)), ra, rb, lat);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
